uart_tx_arb: RTL and testbench

Line-atomic round-robin arbiter that shares one `uart_tx` transmitter among `NREQ` byte producers, such as several debug probes or console sources. Each requester holds the transmitter from its first accepted byte until its byte flagged `last` is accepted, so text lines never interleave. An idle-timeout releases a holder that stalls mid-line. The block sits between the producers and the single `uart_tx` push/full port.

---
 rtl/uart_tx_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 31 +++
 rtl/uart_tx_arb.sv | 101 ++++++++++
 tb/tb_uart_tx_arb.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared state encoding and width helper for the uart_tx arbiter
package uart_tx_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int j;

    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        j    = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            j = j >= NREQ ? j - NREQ : j;
            if (!any && req[j]) begin
                any     = 1'b1;
                pick[j] = 1'b1;
                idx     = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: line-atomic round-robin arbiter sharing one uart_tx among NREQ producers
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   push_i,
    input  logic [8*NREQ-1:0] data_i,
    input  logic [NREQ-1:0]   last_i,
    output logic [NREQ-1:0]   full_o,
    output logic              push_o,
    output logic [7:0]        data_o,
    input  logic              full_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic              timeout_o
);

    localparam int IW = NREQ > 1 ? clog2(NREQ) : 1;
    localparam int CW = TIMEOUT > 0 ? clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d, sel_q, sel_d, pick_idx;
    logic [NREQ-1:0] gnt_q, gnt_d, pick;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pick_any, locked, push_sel, last_sel, accept, expire, release_w;
    logic [7:0]      data_sel;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req  (push_i),
        .ptr  (ptr_q),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        push_sel = 1'b0;
        last_sel = 1'b0;
        data_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (sel_q == IW'(k)) begin
                push_sel = push_i[k];
                last_sel = last_i[k];
                data_sel = data_i[8*k +: 8];
            end
        end
        locked    = state_q == ARB_LOCKED;
        accept    = locked && push_sel && !full_i;
        // expiry is judged on the count this cycle would reach, so an accept here always wins
        expire    = locked && TIMEOUT != 0 && !push_sel && (cnt_q + 1'b1) == TMAX;
        release_w = (accept && last_sel) || expire;
        push_o    = accept;
        data_o    = locked ? data_sel : 8'h00;
        full_o    = locked ? (~gnt_q | {NREQ{full_i}}) : '1;
        gnt_o     = gnt_q;
        timeout_o = expire;
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        if (!locked) begin
            if (pick_any) begin
                state_d = ARB_LOCKED;
                sel_d   = pick_idx;
                gnt_d   = pick;
                cnt_d   = '0;
            end
        end else if (release_w) begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
            ptr_d   = sel_q == IW'(NREQ - 1) ? '0 : sel_q + 1'b1;
        end else if (accept) begin
            cnt_d = '0;
        end else if (!push_sel && cnt_q != TMAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed and randomized checks of uart_tx_arb against a line-level model
module tb_uart_tx_arb;

    localparam int N = 2;
    localparam int TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic [1:0]   push_i = '0;
    logic [15:0]  data_i = '0;
    logic [1:0]   last_i = '0;
    logic [1:0]   full_o;
    logic         push_o;
    logic [7:0]   data_o;
    logic         full_i = 1'b0;
    logic [1:0]   gnt_o;
    logic         timeout_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] q_d [2][$];
    bit         q_l [2][$];
    logic [7:0] out_d [$];
    int         out_w [$];
    int         out_c [$];

    int         m_hold = -1;
    int         m_ptr = 0;
    int         m_quiet = 0;
    int         m_h;
    logic       m_p, m_acc, e_push, e_to;
    logic [7:0] e_data;
    logic [1:0] e_full, e_gnt;

    uart_tx_arb #(.NREQ(N), .TIMEOUT(TIMEOUT)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .push_i    (push_i),
        .data_i    (data_i),
        .last_i    (last_i),
        .full_o    (full_o),
        .push_o    (push_o),
        .data_o    (data_o),
        .full_i    (full_i),
        .gnt_o     (gnt_o),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line-level reference: a holder keeps the port until its last byte is taken
    // or TIMEOUT consecutive cycles pass without it offering a byte.
    always @(negedge clk) begin
        e_push = 1'b0;
        e_data = 8'h00;
        e_full = 2'b11;
        e_gnt  = 2'b00;
        e_to   = 1'b0;
        if (rst_i) begin
            m_hold  = -1;
            m_ptr   = 0;
            m_quiet = 0;
        end else if (m_hold < 0) begin
            for (int i = 0; i < N; i++)
                if (m_hold < 0 && push_i[(m_ptr + i) % N]) m_hold = (m_ptr + i) % N;
            m_quiet = 0;
        end else begin
            m_h   = m_hold;
            m_p   = push_i[m_h];
            m_acc = m_p && !full_i;
            e_push = m_acc;
            e_data = data_i[8*m_h +: 8];
            e_full[m_h] = full_i;
            e_gnt[m_h]  = 1'b1;
            if (m_acc) m_quiet = 0;
            else if (!m_p) m_quiet++;
            e_to = !m_acc && m_quiet == TIMEOUT;
            if ((m_acc && last_i[m_h]) || e_to) begin
                m_hold  = -1;
                m_ptr   = (m_h + 1) % N;
                m_quiet = 0;
            end
        end
        chk("cycle{push,data,full,gnt,to}", {18'd0, push_o, data_o, full_o, gnt_o, timeout_o},
            {18'd0, e_push, e_data, e_full, e_gnt, e_to});
    end

    task automatic drive(input logic [1:0] p, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [1:0] l, input logic f);
        @(posedge clk);
        #1;
        push_i = p;
        data_i = {d1, d0};
        last_i = l;
        full_i = f;
        #2;
        cyc++;
    endtask

    task automatic add_line(input int k, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            q_d[k].push_back(8'(base + 8'(i)));
            q_l[k].push_back(i == n - 1);
        end
    endtask

    task automatic clear_log();
        out_d.delete();
        out_w.delete();
        out_c.delete();
    endtask

    task automatic feed(input int pct, input int fpct, input int stop_n, input int budget);
        int c;
        logic [1:0] p, l;
        logic [7:0] d [2];
        logic f;
        c = 0;
        while ((q_d[0].size() + q_d[1].size()) > 0 && (stop_n == 0 || out_d.size() < stop_n)
               && c < budget) begin
            for (int k = 0; k < 2; k++) begin
                p[k] = 1'b0;
                l[k] = 1'b0;
                d[k] = 8'($urandom);
                if (q_d[k].size() > 0) begin
                    p[k] = $urandom_range(99) < pct;
                    d[k] = q_d[k][0];
                    l[k] = q_l[k][0];
                end
            end
            f = $urandom_range(99) < fpct;
            drive(p, d[0], d[1], l, f);
            if (push_o) begin
                out_d.push_back(data_o);
                out_w.push_back(int'(gnt_o[1]));
                out_c.push_back(cyc);
            end
            for (int k = 0; k < 2; k++)
                if (p[k] && !full_o[k]) begin
                    void'(q_d[k].pop_front());
                    void'(q_l[k].pop_front());
                end
            c++;
        end
        chk("feed_done", (stop_n == 0) ? 32'((q_d[0].size() + q_d[1].size()) == 0)
                                       : 32'(out_d.size() >= stop_n), 1);
    endtask

    initial begin
        int bad;
        repeat (2) @(posedge clk);
        #3;
        chk("reset_full", full_o, 2'b11);
        chk("reset_gnt", gnt_o, 2'b00);
        chk("reset_push", push_o, 1'b0);
        rst_i = 1'b0;

        // contention from ptr=0: req0's whole line, one idle gap, then req1's line
        clear_log();
        add_line(0, 3, 8'hA0);
        add_line(1, 3, 8'hB0);
        feed(100, 0, 0, 40);
        chk("cont_len", out_d.size(), 6);
        for (int i = 0; i < 6 && i < out_d.size(); i++) begin
            chk("cont_byte", out_d[i], i < 3 ? 8'hA0 + 8'(i) : 8'hB0 + 8'(i - 3));
            chk("cont_who", out_w[i], i < 3 ? 0 : 1);
        end
        if (out_c.size() >= 4) chk("cont_gap", out_c[3] - out_c[2], 2);

        // fairness: line owners alternate while both keep requesting
        clear_log();
        add_line(0, 2, 8'h10);
        add_line(0, 2, 8'h12);
        add_line(1, 2, 8'h20);
        add_line(1, 2, 8'h22);
        feed(100, 0, 0, 60);
        chk("fair_len", out_d.size(), 8);
        for (int i = 0; i < 8 && i < out_w.size(); i += 2)
            chk("fair_owner", out_w[i], (i / 2) % 2);

        // single requester "AB\n"
        drive(2'b01, 8'h41, 8'h00, 2'b00, 1'b0);
        chk("s_idle_gnt", gnt_o, 2'b00);
        chk("s_idle_full", full_o, 2'b11);
        drive(2'b01, 8'h41, 8'h00, 2'b00, 1'b0);
        chk("s_gnt", gnt_o, 2'b01);
        chk("s_A", {push_o, data_o}, 9'h141);
        drive(2'b01, 8'h42, 8'h00, 2'b00, 1'b0);
        chk("s_B", {push_o, data_o}, 9'h142);
        drive(2'b01, 8'h0a, 8'h00, 2'b01, 1'b0);
        chk("s_nl", {push_o, data_o}, 9'h10a);
        drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
        chk("s_release", gnt_o, 2'b00);

        // back-pressure must never time out
        clear_log();
        add_line(0, 4, 8'h50);
        feed(100, 0, 2, 20);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            drive(2'b01, q_d[0][0], 8'h00, {1'b0, q_l[0][0]}, 1'b1);
            if (gnt_o != 2'b01 || timeout_o || push_o) bad++;
        end
        chk("bp_hold", bad, 0);
        feed(100, 0, 0, 20);
        chk("bp_len", out_d.size(), 4);
        for (int i = 0; i < 4 && i < out_d.size(); i++) chk("bp_byte", out_d[i], 8'h50 + 8'(i));

        // timeout: req1 stalls after one byte while req0 waits
        drive(2'b10, 8'h00, 8'h55, 2'b00, 1'b0);
        drive(2'b10, 8'h00, 8'h55, 2'b00, 1'b0);
        chk("to_accept", {push_o, data_o, gnt_o}, {1'b1, 8'h55, 2'b10});
        for (int i = 1; i <= 18; i++) begin
            drive(2'b01, 8'h66, 8'h00, 2'b01, 1'b0);
            if (i <= 16) chk("to_pulse", timeout_o, i == 16);
            if (i == 17) chk("to_idle", gnt_o, 2'b00);
            if (i == 18) chk("to_regrant", {gnt_o, push_o, data_o}, {2'b01, 1'b1, 8'h66});
        end
        drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b0);

        // asynchronous reset mid-line
        clear_log();
        add_line(0, 3, 8'h30);
        feed(100, 0, 1, 10);
        drive(2'b01, 8'h31, 8'h00, 2'b00, 1'b0);
        chk("rst_pre", {push_o, data_o}, 9'h131);
        rst_i = 1'b1;
        #1;
        chk("rst_push", push_o, 1'b0);
        chk("rst_full", full_o, 2'b11);
        chk("rst_gnt", gnt_o, 2'b00);
        drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
        drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
        rst_i = 1'b0;
        q_d[0].delete();
        q_l[0].delete();
        clear_log();
        add_line(0, 2, 8'h40);
        feed(100, 0, 0, 10);
        chk("rst_after_len", out_d.size(), 2);
        for (int i = 0; i < 2 && i < out_d.size(); i++) chk("rst_after", out_d[i], 8'h40 + 8'(i));

        // randomized traffic, checked cycle by cycle by the model
        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < 2; k++)
                if ($urandom_range(1) == 1) add_line(k, $urandom_range(1, 5), 8'($urandom));
            feed($urandom_range(60, 100), $urandom_range(0, 40), 0, 2000);
        end
        drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
        drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
